// File: rtl/aes_block_loader.sv
// Byte-serial front end for an aes128_encrypt core. It assembles a key and a
// plaintext block from one byte stream, runs the core, and streams the ciphertext back out.
module aes_block_loader #(
  parameter int DONE_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_is_key,
  output logic         in_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         aes_rst_n,
  output logic [127:0] aes_key,
  output logic [127:0] aes_plaintext,
  input  logic [127:0] aes_ciphertext,
  input  logic         aes_done,
  output logic         busy,
  output logic         timeout_err
);

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] SEND  = 2'd3;

  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  logic [1:0]    state;
  logic [127:0]  key_reg;
  logic [127:0]  pt_reg;
  logic [127:0]  ct_reg;
  logic [4:0]    key_cnt;
  logic [4:0]    pt_cnt;
  logic          key_valid;
  logic [3:0]    out_idx;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_nxt;

  logic          accept;
  logic          key_acc;
  logic          pt_acc;
  logic          pt_full;
  logic [3:0]    key_wr_idx;
  logic [4:0]    key_cnt_nxt;
  logic [4:0]    pt_cnt_nxt;
  logic          key_valid_nxt;

  // Byte j of a block sits at bits [127-8j -: 8]; byte 0 is the MSB.
  function automatic logic [7:0] byte_of(input logic [127:0] v, input logic [3:0] j);
    return 8'(v >> {4'd15 - j, 3'b000});
  endfunction

  function automatic logic [127:0] put_byte(input logic [127:0] v, input logic [3:0] j,
                                            input logic [7:0] b);
    logic [6:0] sh;
    sh = {4'd15 - j, 3'b000};
    return (v & ~(128'hff << sh)) | ({120'd0, b} << sh);
  endfunction

  assign pt_full = (pt_cnt == 5'd16);
  assign accept  = in_valid && in_ready;
  assign key_acc = accept && in_is_key;
  assign pt_acc  = accept && !in_is_key;

  // A key byte arriving on top of a complete key starts a fresh key at byte 0.
  assign key_wr_idx = key_valid ? 4'd0 : key_cnt[3:0];
  assign tmo_nxt    = tmo_cnt + TW'(1);

  always_comb begin
    key_cnt_nxt   = key_cnt;
    key_valid_nxt = key_valid;
    pt_cnt_nxt    = pt_cnt;
    if (key_acc) begin
      if (key_valid) begin
        key_cnt_nxt   = 5'd1;
        key_valid_nxt = 1'b0;
      end else begin
        key_cnt_nxt   = key_cnt + 5'd1;
        key_valid_nxt = (key_cnt == 5'd15);
      end
    end
    if (pt_acc) begin
      pt_cnt_nxt = pt_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= LOAD;
      key_reg     <= '0;
      pt_reg      <= '0;
      ct_reg      <= '0;
      key_cnt     <= '0;
      pt_cnt      <= '0;
      key_valid   <= 1'b0;
      out_idx     <= '0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (key_acc) key_reg <= put_byte(key_reg, key_wr_idx, in_data);
          if (pt_acc)  pt_reg  <= put_byte(pt_reg, pt_cnt[3:0], in_data);
          key_cnt   <= key_cnt_nxt;
          key_valid <= key_valid_nxt;
          pt_cnt    <= pt_cnt_nxt;
          // Decide on the updated counts so START follows the completing byte directly.
          if ((pt_cnt_nxt == 5'd16) && key_valid_nxt) state <= START;
        end
        START: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (aes_done) begin
            ct_reg  <= aes_ciphertext;
            out_idx <= '0;
            pt_cnt  <= '0;
            state   <= SEND;
          end else if (tmo_nxt == TW'(DONE_TIMEOUT)) begin
            // Core never answered: drop this plaintext, keep the key.
            timeout_err <= 1'b1;
            pt_cnt      <= '0;
            state       <= LOAD;
          end else begin
            tmo_cnt <= tmo_nxt;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_idx == 4'd15) begin
              pt_cnt <= '0;
              state  <= LOAD;
            end else begin
              out_idx <= out_idx + 4'd1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Handshake outputs are forced low for the whole reset, not just after the first edge.
  assign in_ready      = rst_n && (state == LOAD) && !(!in_is_key && pt_full);
  assign out_valid     = rst_n && (state == SEND);
  assign out_data      = out_valid ? byte_of(ct_reg, out_idx) : 8'h00;
  assign busy          = rst_n && (state != LOAD);
  assign aes_rst_n     = rst_n && (state != START);
  assign aes_key       = key_reg;
  assign aes_plaintext = pt_reg;

endmodule

// File: tb/tb_aes_block_loader.sv
// Bench for aes_block_loader: a latency-randomised stand-in for the AES core
// plus directed and random block transfers checked against a byte-level model.
module tb_aes_block_loader;

  localparam int TMO = 20;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_is_key;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         aes_rst_n;
  logic [127:0] aes_key;
  logic [127:0] aes_plaintext;
  logic [127:0] aes_ciphertext;
  logic         aes_done;
  logic         busy;
  logic         timeout_err;

  logic         core_done = 1'b0;
  logic [127:0] core_ct = '0;
  int           lat_cnt = 0;
  bit           tie_done = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [127:0] key_m;
  logic [127:0] pt_m;

  always #5 clk = ~clk;

  aes_block_loader #(.DONE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_is_key(in_is_key), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .aes_rst_n(aes_rst_n),
    .aes_key(aes_key), .aes_plaintext(aes_plaintext),
    .aes_ciphertext(aes_ciphertext), .aes_done(aes_done), .busy(busy),
    .timeout_err(timeout_err)
  );

  // Core stand-in: the two reference vectors give true AES results, anything else a keyed mix.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == K1 && p == P1) return C1;
    if (k == K2 && p == P2) return C2;
    return (k ^ {p[62:0], p[127:63]}) + 128'h9e3779b97f4a7c15f39cc0605cedc834;
  endfunction

  always @(posedge clk) begin
    if (!aes_rst_n) begin
      core_done <= 1'b0;
      lat_cnt   <= $urandom_range(2, 8);
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
    end else begin
      core_done <= 1'b1;
      core_ct   <= core_fn(aes_key, aes_plaintext);
    end
  end

  assign aes_done       = core_done && !tie_done;
  assign aes_ciphertext = core_ct;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [127:0] v, input int j);
    logic [127:0] t;
    t = v << (8 * j);
    return t[127:120];
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic is_key);
    in_data   = d;
    in_is_key = is_key;
    in_valid  = 1'b1;
    #1;
    for (int t = 0; t < 100; t++) begin
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    check("send_accept", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    for (int i = 0; i < 16; i++) send_byte(byte_at(k, i), 1'b1);
    key_m = k;
  endtask

  task automatic load_pt(input logic [127:0] p);
    for (int i = 0; i < 16; i++) send_byte(byte_at(p, i), 1'b0);
    pt_m = p;
  endtask

  // Called in the cycle right after the completing byte was accepted.
  task automatic check_start();
    check("start_aes_rst_n", {127'd0, aes_rst_n}, 128'd0);
    check("start_busy", {127'd0, busy}, 128'd1);
    tick();
    check("wait_aes_rst_n", {127'd0, aes_rst_n}, 128'd1);
    check("wait_out_valid", {127'd0, out_valid}, 128'd0);
    check("wait_key", aes_key, key_m);
    check("wait_pt", aes_plaintext, pt_m);
  endtask

  task automatic recv(input logic [127:0] exp, input bit stall, input int nbytes);
    int   got;
    bit   stalled;
    logic [7:0] held;
    got = 0;
    stalled = 1'b0;
    held = 8'h00;
    for (int t = 0; t < 1000 && got < nbytes; t++) begin
      if (out_valid && stalled) check("out_hold", {120'd0, out_data}, {120'd0, held});
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        if (out_ready) begin
          check("out_byte", {120'd0, out_data}, {120'd0, byte_at(exp, got)});
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = out_data;
        end
      end
      tick();
    end
    out_ready = 1'b0;
    check("recv_count", 128'(got), 128'(nbytes));
    if (nbytes == 16) begin
      check("send_done_busy", {127'd0, busy}, 128'd0);
      check("send_pt_stable", aes_plaintext, pt_m);
    end
  endtask

  initial begin
    logic [127:0] kr;
    logic [127:0] pr;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_is_key = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    key_m     = '0;
    pt_m      = '0;

    // Reset state
    tick(); tick(); tick();
    check("rst_in_ready", {127'd0, in_ready}, 128'd0);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_data", {120'd0, out_data}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_aes_rst_n", {127'd0, aes_rst_n}, 128'd0);
    check("rst_timeout_err", {127'd0, timeout_err}, 128'd0);
    check("rst_key", aes_key, 128'd0);
    check("rst_pt", aes_plaintext, 128'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", {127'd0, in_ready}, 128'd1);

    // Reference vector 1
    load_key(K1);
    load_pt(P1);
    check_start();
    recv(C1, 1'b0, 16);

    // Key retained: plaintext only
    pr = {$urandom, $urandom, $urandom, $urandom};
    load_pt(pr);
    check_start();
    recv(core_fn(key_m, pt_m), 1'b0, 16);

    // Reference vector 2 with a new key
    load_key(K2);
    load_pt(P2);
    check_start();
    recv(C2, 1'b1, 16);

    // Interleaved, plaintext completes first; 17th plaintext byte must stall
    kr = {$urandom, $urandom, $urandom, $urandom};
    pr = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 15; i++) begin
      send_byte(byte_at(kr, i), 1'b1);
      send_byte(byte_at(pr, i), 1'b0);
    end
    send_byte(byte_at(pr, 15), 1'b0);
    check("ilv_no_start", {127'd0, aes_rst_n}, 128'd1);
    check("ilv_not_busy", {127'd0, busy}, 128'd0);
    in_data = 8'h5a; in_is_key = 1'b0; in_valid = 1'b1;
    #1;
    check("pt17_in_ready", {127'd0, in_ready}, 128'd0);
    tick();
    check("pt17_still_ready", {127'd0, in_ready}, 128'd0);
    check("pt17_no_start", {127'd0, busy}, 128'd0);
    in_valid = 1'b0;
    send_byte(byte_at(kr, 15), 1'b1);
    key_m = kr;
    pt_m  = pr;
    check_start();
    recv(core_fn(kr, pr), 1'b1, 16);

    // Missing aes_done
    tie_done = 1'b1;
    pr = {$urandom, $urandom, $urandom, $urandom};
    load_pt(pr);
    check_start();
    for (int c = 1; c < TMO; c++) tick();
    check("tmo_before_err", {127'd0, timeout_err}, 128'd0);
    check("tmo_before_busy", {127'd0, busy}, 128'd1);
    tick();
    check("tmo_err", {127'd0, timeout_err}, 128'd1);
    check("tmo_load_busy", {127'd0, busy}, 128'd0);
    check("tmo_in_ready", {127'd0, in_ready}, 128'd1);
    check("tmo_key_kept", aes_key, key_m);
    tie_done = 1'b0;
    pr = {$urandom, $urandom, $urandom, $urandom};
    load_pt(pr);
    check_start();
    recv(core_fn(key_m, pr), 1'b1, 16);
    check("tmo_err_sticky", {127'd0, timeout_err}, 128'd1);

    // Reset in the middle of SEND
    pr = {$urandom, $urandom, $urandom, $urandom};
    load_pt(pr);
    check_start();
    recv(core_fn(key_m, pr), 1'b0, 5);
    rst_n = 1'b0;
    #1;
    check("mid_out_valid", {127'd0, out_valid}, 128'd0);
    check("mid_aes_rst_n", {127'd0, aes_rst_n}, 128'd0);
    check("mid_in_ready", {127'd0, in_ready}, 128'd0);
    check("mid_out_data", {120'd0, out_data}, 128'd0);
    tick(); tick();
    check("mid_key_clr", aes_key, 128'd0);
    check("mid_err_clr", {127'd0, timeout_err}, 128'd0);
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", {127'd0, in_ready}, 128'd1);
    pr = {$urandom, $urandom, $urandom, $urandom};
    load_pt(pr);
    tick(); tick();
    check("mid_kv_no_start", {127'd0, aes_rst_n}, 128'd1);
    check("mid_kv_not_busy", {127'd0, busy}, 128'd0);
    load_key(K1);
    check_start();
    recv(core_fn(K1, pr), 1'b1, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
